// File: rtl/complete_graph_valve_sequencer_pkg.sv
// Shared types and edge-numbering helpers for the complete-graph valve sequencer.
// Optional transfer counter is enabled with the COMPLETE_SEQ_COUNT_EN macro.
package complete_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    FLOW  = 2'd2,
    CLOSE = 2'd3
  } seq_state_t;

  function automatic int edge_count(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Row-major numbering of the upper triangle of the adjacency matrix (a < b).
  function automatic int edge_index(input int a, input int b, input int n);
    return a * n - a * (a + 1) / 2 + (b - a - 1);
  endfunction

  function automatic int idx_width(input int e);
    return (e > 1) ? $clog2(e) : 1;
  endfunction

endpackage

// File: rtl/complete_graph_valve_sequencer_if.sv
// Transfer-request channel between the chip scheduler (master) and the sequencer (slave).
interface complete_graph_valve_sequencer_if #(
  parameter int N_PORTS = 8,
  parameter int HOLD_W  = 8
);
  localparam int PW = $clog2(N_PORTS);

  logic              req_valid;
  logic              req_ready;
  logic [PW-1:0]     req_src;
  logic [PW-1:0]     req_dst;
  logic [HOLD_W-1:0] req_hold;

  modport master (
    output req_valid, req_src, req_dst, req_hold,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_src, req_dst, req_hold,
    output req_ready
  );

endinterface

// File: rtl/complete_graph_valve_sequencer_edge_index.sv
// Combinational port pair -> undirected edge index, with self-loop and range checks.
module complete_edge_index
  import complete_seq_pkg::*;
#(
  parameter  int N_PORTS = 8,
  localparam int PW      = $clog2(N_PORTS),
  localparam int E       = edge_count(N_PORTS),
  localparam int EW      = idx_width(E)
) (
  input  logic [PW-1:0] src,
  input  logic [PW-1:0] dst,
  output logic [EW-1:0] idx,
  output logic          valid
);

  int a;
  int b;

  always_comb begin
    a     = (src < dst) ? int'(src) : int'(dst);
    b     = (src < dst) ? int'(dst) : int'(src);
    valid = (src != dst) && (int'(src) < N_PORTS) && (int'(dst) < N_PORTS);
    idx   = valid ? EW'(edge_index(a, b, N_PORTS)) : '0;
  end

endmodule

// File: rtl/complete_graph_valve_sequencer.sv
// Edge-valve sequencer for K_N: OPEN -> FLOW -> CLOSE per accepted transfer, one valve at a time.
// Define COMPLETE_SEQ_COUNT_EN to add the saturating xfer_count output.
module complete_graph_valve_sequencer
  import complete_seq_pkg::*;
#(
  parameter  int N_PORTS = 8,
  parameter  int SETTLE  = 2,
  parameter  int HOLD_W  = 8,
  localparam int E       = edge_count(N_PORTS),
  localparam int EW      = idx_width(E)
) (
  input  logic                              clk,
  input  logic                              rst,
  complete_graph_valve_sequencer_if.slave   req,
  output logic [E-1:0]                      valve_open,
  output logic [EW-1:0]                     active_edge,
  output logic                              busy,
  output logic                              done,
  output logic                              err
`ifdef COMPLETE_SEQ_COUNT_EN
  ,
  output logic [15:0]                       xfer_count
`endif
);

  // Counter must hold both the settle reload and the largest hold value.
  localparam int SW = $clog2(SETTLE + 1);
  localparam int CW = (HOLD_W > SW) ? HOLD_W : SW;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  seq_state_t        state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [HOLD_W-1:0] hold_r, hold_n;
  logic [EW-1:0]     edge_n;
  logic [E-1:0]      valve_n;
  logic              done_n, err_n;
  logic [EW-1:0]     req_idx;
  logic              req_ok;
  logic              accept;

  complete_edge_index #(.N_PORTS(N_PORTS)) u_edge_index (
    .src   (req.req_src),
    .dst   (req.req_dst),
    .idx   (req_idx),
    .valid (req_ok)
  );

  assign req.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = req.req_valid && (state == IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hold_n  = hold_r;
    edge_n  = active_edge;
    valve_n = valve_open;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_ok) begin
            state_n          = OPEN;
            cnt_n            = SETTLE_LAST;
            hold_n           = req.req_hold;
            edge_n           = req_idx;
            valve_n          = '0;
            valve_n[req_idx] = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      OPEN: begin
        if (cnt == '0) begin
          if (hold_r != '0) begin
            state_n = FLOW;
            cnt_n   = CW'(hold_r - 1'b1);
          end else begin
            state_n = CLOSE;
            cnt_n   = SETTLE_LAST;
            valve_n = '0;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      FLOW: begin
        if (cnt == '0) begin
          state_n = CLOSE;
          cnt_n   = SETTLE_LAST;
          valve_n = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      CLOSE: begin
        if (cnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valve_open  <= '0;
      active_edge <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      valve_open  <= valve_n;
      active_edge <= edge_n;
      done        <= done_n;
      err         <= err_n;
    end
  end

  // Phase counter and latched hold are only meaningful outside IDLE.
  always_ff @(posedge clk) begin
    cnt    <= cnt_n;
    hold_r <= hold_n;
  end

`ifdef COMPLETE_SEQ_COUNT_EN
  logic [15:0] xfer_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (done_n && (xfer_cnt != 16'hFFFF)) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

  assign xfer_count = xfer_cnt;
`endif

endmodule
